// File: rtl/text_buffer_scheduler_if.sv
// text_buffer_scheduler_if: CPU, bulk-operation and RAM port A signals of the text-buffer scheduler
interface text_buffer_scheduler_if #(
  parameter int LENGTH = 2400
);
  localparam int AW = $clog2(LENGTH);
  logic cpu_request;
  logic cpu_write;
  logic [AW-1:0] cpu_address;
  logic [7:0] cpu_data_in;
  logic [7:0] cpu_data_out;
  logic cpu_ready;
  logic clear_request;
  logic scroll_request;
  logic busy;
  logic [AW-1:0] ram_address;
  logic [7:0] ram_data_in;
  logic ram_write_enable;
  logic [7:0] ram_data_out;
  modport master (
    output cpu_request, cpu_write, cpu_address, cpu_data_in, clear_request, scroll_request, ram_data_out,
    input cpu_data_out, cpu_ready, busy, ram_address, ram_data_in, ram_write_enable
  );
  modport slave (
    input cpu_request, cpu_write, cpu_address, cpu_data_in, clear_request, scroll_request, ram_data_out,
    output cpu_data_out, cpu_ready, busy, ram_address, ram_data_in, ram_write_enable
  );
endinterface

// File: rtl/text_buffer_scheduler.sv
// text_buffer_scheduler: arbitrates text-buffer RAM port A between CPU byte access, clear-screen and scroll-up
module text_buffer_scheduler #(
  parameter int COLUMNS = 80,
  parameter int ROWS = 30,
  parameter int LENGTH = COLUMNS * ROWS,
  parameter logic [7:0] FILL_CHAR = 8'h20
) (
  input logic CLOCK_50,
  input logic reset,
  text_buffer_scheduler_if.slave bus
);
  localparam int AW = $clog2(LENGTH);
  localparam int CW = $clog2(LENGTH + 1);
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] CPU_RD_ADDR = 3'd1;
  localparam logic [2:0] CPU_RD_DATA = 3'd2;
  localparam logic [2:0] CLEAR = 3'd3;
  localparam logic [2:0] SCROLL_RD = 3'd4;
  localparam logic [2:0] SCROLL_WR = 3'd5;
  localparam logic [2:0] SCROLL_FILL = 3'd6;
  localparam logic [CW-1:0] LAST = CW'(LENGTH - 1);
  localparam logic [CW-1:0] MOVE_LAST = CW'(LENGTH - COLUMNS - 1);
  localparam logic [CW-1:0] FILL_FIRST = CW'(LENGTH - COLUMNS);
  localparam logic [CW-1:0] COLS = CW'(COLUMNS);
  localparam logic [AW-1:0] ADDR_LAST = AW'(LENGTH - 1);
  logic [2:0] state;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nx;
  logic [7:0] data_q;
  logic clear_pending;
  logic scroll_pending;
  logic start_clear;
  logic start_scroll;
  logic cpu_go;
  logic cpu_in_range;
  always_comb begin
    count_nx = count + CW'(1);
    start_clear = state == IDLE && clear_pending;
    start_scroll = state == IDLE && !clear_pending && scroll_pending;
    cpu_go = bus.cpu_request && !bus.cpu_ready;
    cpu_in_range = bus.cpu_address <= ADDR_LAST;
  end
  assign bus.ram_data_in = state == SCROLL_WR ? bus.ram_data_out : data_q;
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
      data_q <= '0;
      clear_pending <= 1'b0;
      scroll_pending <= 1'b0;
      bus.cpu_data_out <= '0;
      bus.cpu_ready <= 1'b0;
      bus.busy <= 1'b0;
      bus.ram_address <= '0;
      bus.ram_write_enable <= 1'b0;
    end else begin
      clear_pending <= bus.clear_request || (clear_pending && !start_clear);
      scroll_pending <= !(bus.clear_request || clear_pending) && (bus.scroll_request || (scroll_pending && !start_scroll));
      bus.cpu_ready <= 1'b0;
      case (state)
        IDLE: begin
          bus.ram_write_enable <= 1'b0;
          if (clear_pending) begin
            state <= CLEAR;
            count <= '0;
            data_q <= FILL_CHAR;
            bus.ram_address <= '0;
            bus.ram_write_enable <= 1'b1;
            bus.busy <= 1'b1;
          end else if (scroll_pending) begin
            state <= SCROLL_RD;
            count <= '0;
            bus.ram_address <= AW'(COLS);
            bus.busy <= 1'b1;
          end else if (cpu_go && bus.cpu_write) begin
            if (cpu_in_range) begin
              data_q <= bus.cpu_data_in;
              bus.ram_address <= bus.cpu_address;
              bus.ram_write_enable <= 1'b1;
            end
            bus.cpu_ready <= 1'b1;
          end else if (cpu_go) begin
            state <= CPU_RD_ADDR;
            if (cpu_in_range) bus.ram_address <= bus.cpu_address;
          end
        end
        CPU_RD_ADDR: state <= CPU_RD_DATA;
        CPU_RD_DATA: begin
          state <= IDLE;
          bus.cpu_data_out <= cpu_in_range ? bus.ram_data_out : 8'h00;
          bus.cpu_ready <= 1'b1;
        end
        CLEAR: begin
          if (count == LAST) begin
            state <= IDLE;
            bus.ram_write_enable <= 1'b0;
            bus.busy <= 1'b0;
          end else begin
            count <= count_nx;
            bus.ram_address <= AW'(count_nx);
          end
        end
        SCROLL_RD: begin
          state <= SCROLL_WR;
          bus.ram_address <= AW'(count);
          bus.ram_write_enable <= 1'b1;
        end
        SCROLL_WR: begin
          if (count == MOVE_LAST) begin
            state <= SCROLL_FILL;
            count <= FILL_FIRST;
            data_q <= FILL_CHAR;
            bus.ram_address <= AW'(FILL_FIRST);
          end else begin
            state <= SCROLL_RD;
            count <= count_nx;
            bus.ram_address <= AW'(count_nx + COLS);
            bus.ram_write_enable <= 1'b0;
          end
        end
        SCROLL_FILL: begin
          if (count == LAST) begin
            state <= IDLE;
            bus.ram_write_enable <= 1'b0;
            bus.busy <= 1'b0;
          end else begin
            count <= count_nx;
            bus.ram_address <= AW'(count_nx);
          end
        end
        default: begin
          state <= IDLE;
          bus.ram_write_enable <= 1'b0;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_text_buffer_scheduler.sv
// tb_text_buffer_scheduler: directed checks of CPU access, clear, scroll, coalescing and reset with a RAM model
module tb_text_buffer_scheduler;
  localparam int LENGTH = 2400;
  localparam int COLUMNS = 80;
  logic CLOCK_50 = 1'b0;
  logic reset = 1'b1;
  always #5 CLOCK_50 = ~CLOCK_50;
  text_buffer_scheduler_if #(.LENGTH(LENGTH)) bus();
  text_buffer_scheduler dut (.CLOCK_50(CLOCK_50), .reset(reset), .bus(bus));
  logic [7:0] mem [0:LENGTH-1];
  logic fill_pat = 1'b0;
  int checks = 0;
  int errors = 0;
  int run_len = 0;
  int n_runs = 0;
  int ready_busy = 0;
  int runs [0:15];
  logic last_we;
  int last_addr;
  logic [7:0] last_din;
  logic [7:0] d;
  int lat;
  int base;
  always @(posedge CLOCK_50) begin
    if (fill_pat) for (int i = 0; i < LENGTH; i++) mem[i] <= 8'(i);
    else if (bus.ram_write_enable && int'(bus.ram_address) < LENGTH) mem[bus.ram_address] <= bus.ram_data_in;
    bus.ram_data_out <= int'(bus.ram_address) < LENGTH ? mem[bus.ram_address] : 8'hEE;
  end
  always @(posedge CLOCK_50) begin
    if (bus.busy) run_len <= run_len + 1;
    else if (run_len != 0) begin
      runs[n_runs % 16] <= run_len;
      n_runs <= n_runs + 1;
      run_len <= 0;
    end
    if (bus.cpu_ready && bus.busy) ready_busy <= ready_busy + 1;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cpu_access(input logic wr, input int addr, input logic [7:0] din, output logic [7:0] dout, output int n);
    bus.cpu_request = 1'b1;
    bus.cpu_write = wr;
    bus.cpu_address = 12'(addr);
    bus.cpu_data_in = din;
    n = 0;
    do begin
      @(negedge CLOCK_50);
      n++;
    end while (!bus.cpu_ready && n < 8000);
    dout = bus.cpu_data_out;
    last_we = bus.ram_write_enable;
    last_addr = int'(bus.ram_address);
    last_din = bus.ram_data_in;
    @(negedge CLOCK_50);
    bus.cpu_request = 1'b0;
  endtask
  task automatic pulse(input logic clr);
    if (clr) bus.clear_request = 1'b1;
    else bus.scroll_request = 1'b1;
    @(negedge CLOCK_50);
    bus.clear_request = 1'b0;
    bus.scroll_request = 1'b0;
  endtask
  task automatic wait_busy(input string tag, input logic level);
    int n = 0;
    while (bus.busy !== level && n < 10000) begin
      @(negedge CLOCK_50);
      n++;
    end
    check(tag, 32'(bus.busy), 32'(level));
  endtask
  task automatic preload();
    fill_pat = 1'b1;
    @(negedge CLOCK_50);
    fill_pat = 1'b0;
  endtask
  function automatic int region_bad(input int lo, input int hi, input int mode);
    int bad = 0;
    for (int i = lo; i <= hi; i++) begin
      logic [7:0] e;
      e = mode == 0 ? 8'h20 : mode == 1 ? 8'(i) : 8'(i + COLUMNS);
      if (mem[i] !== e) bad++;
    end
    return bad;
  endfunction
  initial begin
    bus.cpu_request = 1'b0;
    bus.cpu_write = 1'b0;
    bus.cpu_address = '0;
    bus.cpu_data_in = '0;
    bus.clear_request = 1'b0;
    bus.scroll_request = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    check("rst_ready", 32'(bus.cpu_ready), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_we", 32'(bus.ram_write_enable), 0);
    check("rst_addr", 32'(bus.ram_address), 0);
    check("rst_dout", 32'(bus.cpu_data_out), 0);
    check("rst_din", 32'(bus.ram_data_in), 0);
    reset = 1'b0;
    @(negedge CLOCK_50);
    cpu_access(1'b1, 5, 8'h41, d, lat);
    check("wr_lat", lat, 1);
    check("wr_we", 32'(last_we), 1);
    check("wr_addr", last_addr, 5);
    check("wr_data", 32'(last_din), 32'h41);
    check("wr_no_repeat", 32'(bus.ram_write_enable), 0);
    cpu_access(1'b0, 5, 8'h00, d, lat);
    check("rd_lat", lat, 3);
    check("rd_data", 32'(d), 32'h41);
    cpu_access(1'b1, 2399, 8'hA5, d, lat);
    check("wr_last_we", 32'(last_we), 1);
    cpu_access(1'b0, 2399, 8'h00, d, lat);
    check("rd_last_lat", lat, 3);
    check("rd_last_data", 32'(d), 32'hA5);
    cpu_access(1'b1, 2400, 8'h77, d, lat);
    check("oor_wr_lat", lat, 1);
    check("oor_wr_we", 32'(last_we), 0);
    cpu_access(1'b0, 4000, 8'h00, d, lat);
    check("oor_rd_lat", lat, 3);
    check("oor_rd_data", 32'(d), 0);
    preload();
    pulse(1'b1);
    wait_busy("clr_start", 1'b1);
    cpu_access(1'b0, 7, 8'h00, d, lat);
    check("clr_cpu_lat", lat, 2403);
    check("clr_cpu_data", 32'(d), 32'h20);
    check("clr_ready_busy", ready_busy, 0);
    check("clr_len", runs[(n_runs - 1) % 16], 2400);
    check("clr_mem", region_bad(0, LENGTH - 1, 0), 0);
    preload();
    pulse(1'b0);
    wait_busy("scr_start", 1'b1);
    wait_busy("scr_end", 1'b0);
    @(negedge CLOCK_50);
    check("scr_len", runs[(n_runs - 1) % 16], 4720);
    check("scr_mem0", 32'(mem[0]), 32'h50);
    check("scr_mem2319", 32'(mem[2319]), 32'h5F);
    check("scr_moved", region_bad(0, LENGTH - COLUMNS - 1, 2), 0);
    check("scr_fill", region_bad(LENGTH - COLUMNS, LENGTH - 1, 0), 0);
    cpu_access(1'b0, 0, 8'h00, d, lat);
    check("scr_rd0", 32'(d), 32'h50);
    preload();
    pulse(1'b0);
    wait_busy("sc_start", 1'b1);
    base = n_runs;
    for (int k = 0; k < 3; k++) begin
      repeat (10) @(negedge CLOCK_50);
      pulse(1'b0);
    end
    repeat (10) @(negedge CLOCK_50);
    pulse(1'b1);
    wait_busy("sc_gap", 1'b0);
    @(negedge CLOCK_50);
    check("sc_clear_start", 32'(bus.busy), 1);
    wait_busy("sc_clear_end", 1'b0);
    repeat (10) @(negedge CLOCK_50);
    check("sc_runs", n_runs - base, 2);
    check("sc_run0", runs[base % 16], 4720);
    check("sc_run1", runs[(base + 1) % 16], 2400);
    check("sc_mem", region_bad(0, LENGTH - 1, 0), 0);
    preload();
    pulse(1'b1);
    wait_busy("rc_start", 1'b1);
    repeat (50) @(negedge CLOCK_50);
    pulse(1'b0);
    repeat (49) @(negedge CLOCK_50);
    reset = 1'b1;
    @(negedge CLOCK_50);
    reset = 1'b0;
    check("rc_busy", 32'(bus.busy), 0);
    check("rc_we", 32'(bus.ram_write_enable), 0);
    check("rc_ready", 32'(bus.cpu_ready), 0);
    repeat (6) @(negedge CLOCK_50);
    check("rc_no_pending", 32'(bus.busy), 0);
    check("rc_cleared", region_bad(0, 95, 0), 0);
    check("rc_untouched", region_bad(110, LENGTH - 1, 1), 0);
    cpu_access(1'b0, 1000, 8'h00, d, lat);
    check("rc_rd_lat", lat, 3);
    check("rc_rd_data", 32'(d), 32'hE8);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
